// File: rtl/weather_pkg.sv
// Shared types and widths for the daily weather feature builder.
package weather_pkg;
   localparam int FEAT_W = 4;
   localparam int PSUM_W = 12;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_ACCUM = 1'b1
   } acc_state_e;
endpackage

// File: rtl/daily_feature_builder_if.sv
// Sample input, feature output handshake and status bundle for daily_feature_builder.
// Optional out_sample_cnt exists only when DFB_SAMPLE_CNT_EN is defined.
interface daily_feature_builder_if;
   import weather_pkg::*;

   logic                     sample_valid;
   logic signed [7:0]        sample_temp;
   logic        [7:0]        sample_precip;
   logic        [7:0]        sample_wind;
   logic                     day_end;
   logic                     feat_ready;
   logic                     feat_valid;
   logic        [FEAT_W-1:0] out_temp_max;
   logic        [FEAT_W-1:0] out_temp_min;
   logic        [FEAT_W-1:0] out_precipitation;
   logic        [FEAT_W-1:0] out_wind;
   logic                     overrun;
`ifdef DFB_SAMPLE_CNT_EN
   logic        [7:0]        out_sample_cnt;
`endif

   modport master (
      output sample_valid, sample_temp, sample_precip, sample_wind, day_end, feat_ready,
      input  feat_valid, out_temp_max, out_temp_min, out_precipitation, out_wind, overrun
`ifdef DFB_SAMPLE_CNT_EN
      , input out_sample_cnt
`endif
   );

   modport slave (
      input  sample_valid, sample_temp, sample_precip, sample_wind, day_end, feat_ready,
      output feat_valid, out_temp_max, out_temp_min, out_precipitation, out_wind, overrun
`ifdef DFB_SAMPLE_CNT_EN
      , output out_sample_cnt
`endif
   );
endinterface

// File: rtl/feature_quantizer.sv
// Combinational bias, arithmetic right shift and clamp to [0, 2**FEAT_W-1] for one field.
module feature_quantizer
   import weather_pkg::*;
#(
   parameter int IN_W   = 10,
   parameter int OFFSET = 0,
   parameter int SHIFT  = 0
) (
   input  logic signed [IN_W-1:0]   i_value,
   output logic        [FEAT_W-1:0] o_code
);
   localparam logic signed [IN_W-1:0] OFFS     = IN_W'(OFFSET);
   localparam logic signed [IN_W-1:0] CODE_MAX = IN_W'((1 << FEAT_W) - 1);

   logic signed [IN_W-1:0] w_biased;
   logic signed [IN_W-1:0] w_shifted;

   assign w_biased  = i_value + OFFS;
   assign w_shifted = w_biased >>> SHIFT;

   // NOTE: o_code is assigned on every path, so no latch is inferred.
   always_comb begin
      if (w_shifted[IN_W-1])
         o_code = '0;
      else if (w_shifted > CODE_MAX)
         o_code = FEAT_W'(CODE_MAX);
      else
         o_code = w_shifted[FEAT_W-1:0];
   end
endmodule

// File: rtl/daily_feature_builder.sv
// Accumulates one day of weather samples and presents quantized features in a one-deep slot.
// Define DFB_SAMPLE_CNT_EN to add the per-day sample count output.
module daily_feature_builder
   import weather_pkg::*;
#(
   parameter int TEMP_OFFSET  = 12,
   parameter int TEMP_SHIFT   = 2,
   parameter int PRECIP_SHIFT = 2,
   parameter int WIND_SHIFT   = 1
) (
   input logic                    CLOCK_50,
   input logic                    rst,
   daily_feature_builder_if.slave bus
);
   acc_state_e               r_state;
   logic signed [7:0]        r_tmax, r_tmin;
   logic        [PSUM_W-1:0] r_psum;
   logic        [7:0]        r_wmax;
   logic                     r_feat_valid, r_overrun;
   logic        [FEAT_W-1:0] r_out_tmax, r_out_tmin, r_out_precip, r_out_wind;

   logic signed [7:0]        w_tmax_nx, w_tmin_nx;
   logic        [PSUM_W-1:0] w_psum_nx;
   logic        [7:0]        w_wmax_nx;
   logic        [PSUM_W:0]   w_psum_add;
   logic        [FEAT_W-1:0] w_q_tmax, w_q_tmin, w_q_precip, w_q_wind;
   logic                     w_close, w_slot_free, w_load;

   assign w_psum_add = {1'b0, r_psum} + {{(PSUM_W-7){1'b0}}, bus.sample_precip};

   // Day state including this cycle's sample, so a sample alongside day_end joins the closing day.
   always_comb begin
      w_tmax_nx = r_tmax;
      w_tmin_nx = r_tmin;
      w_psum_nx = r_psum;
      w_wmax_nx = r_wmax;
      if (bus.sample_valid) begin
         if (r_state == ST_EMPTY) begin
            w_tmax_nx = bus.sample_temp;
            w_tmin_nx = bus.sample_temp;
            w_psum_nx = {{(PSUM_W-8){1'b0}}, bus.sample_precip};
            w_wmax_nx = bus.sample_wind;
         end else begin
            if (bus.sample_temp > r_tmax) w_tmax_nx = bus.sample_temp;
            if (bus.sample_temp < r_tmin) w_tmin_nx = bus.sample_temp;
            w_psum_nx = w_psum_add[PSUM_W] ? '1 : w_psum_add[PSUM_W-1:0];
            if (bus.sample_wind > r_wmax) w_wmax_nx = bus.sample_wind;
         end
      end
   end

   assign w_close     = bus.day_end && (r_state == ST_ACCUM || bus.sample_valid);
   assign w_slot_free = !r_feat_valid || bus.feat_ready;
   assign w_load      = w_close && w_slot_free;

   feature_quantizer #(.IN_W(10), .OFFSET(TEMP_OFFSET), .SHIFT(TEMP_SHIFT)) u_q_tmax (
      .i_value({{2{w_tmax_nx[7]}}, w_tmax_nx}), .o_code(w_q_tmax));
   feature_quantizer #(.IN_W(10), .OFFSET(TEMP_OFFSET), .SHIFT(TEMP_SHIFT)) u_q_tmin (
      .i_value({{2{w_tmin_nx[7]}}, w_tmin_nx}), .o_code(w_q_tmin));
   feature_quantizer #(.IN_W(PSUM_W+1), .OFFSET(0), .SHIFT(PRECIP_SHIFT)) u_q_precip (
      .i_value({1'b0, w_psum_nx}), .o_code(w_q_precip));
   feature_quantizer #(.IN_W(9), .OFFSET(0), .SHIFT(WIND_SHIFT)) u_q_wind (
      .i_value({1'b0, w_wmax_nx}), .o_code(w_q_wind));

   // NOTE: sequential state uses non-blocking assignments only; async reset clears every register.
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_tmax  <= '0;
         r_tmin  <= '0;
         r_psum  <= '0;
         r_wmax  <= '0;
      end else begin
         r_tmax <= w_tmax_nx;
         r_tmin <= w_tmin_nx;
         r_psum <= w_psum_nx;
         r_wmax <= w_wmax_nx;
         if (w_close)
            r_state <= ST_EMPTY;
         else if (bus.sample_valid)
            r_state <= ST_ACCUM;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         r_feat_valid <= 1'b0;
         r_overrun    <= 1'b0;
         r_out_tmax   <= '0;
         r_out_tmin   <= '0;
         r_out_precip <= '0;
         r_out_wind   <= '0;
      end else begin
         if (w_load) begin
            r_feat_valid <= 1'b1;
            r_out_tmax   <= w_q_tmax;
            r_out_tmin   <= w_q_tmin;
            r_out_precip <= w_q_precip;
            r_out_wind   <= w_q_wind;
         end else if (bus.feat_ready) begin
            r_feat_valid <= 1'b0;
         end
         if (w_close && !w_slot_free)
            r_overrun <= 1'b1;
      end
   end

`ifdef DFB_SAMPLE_CNT_EN
   logic [7:0] r_cnt, r_out_cnt, w_cnt_nx;

   always_comb begin
      w_cnt_nx = r_cnt;
      if (bus.sample_valid) begin
         if (r_state == ST_EMPTY)
            w_cnt_nx = 8'd1;
         else if (r_cnt != 8'hFF)
            w_cnt_nx = r_cnt + 8'd1;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_out_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nx;
         if (w_load) r_out_cnt <= w_cnt_nx;
      end
   end

   assign bus.out_sample_cnt = r_out_cnt;
`endif

   assign bus.feat_valid        = r_feat_valid;
   assign bus.overrun           = r_overrun;
   assign bus.out_temp_max      = r_out_tmax;
   assign bus.out_temp_min      = r_out_tmin;
   assign bus.out_precipitation = r_out_precip;
   assign bus.out_wind          = r_out_wind;
endmodule

// File: tb/tb_daily_feature_builder.sv
// Directed testbench for daily_feature_builder with hand-computed feature codes.
module tb_daily_feature_builder;
   logic CLOCK_50;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   daily_feature_builder_if bus ();

   daily_feature_builder dut (
      .CLOCK_50(CLOCK_50),
      .rst     (rst),
      .bus     (bus.slave)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present inputs for one clock; results are visible at the following negedge.
   task automatic drive(input logic sv, input logic signed [7:0] t, input logic [7:0] p,
                        input logic [7:0] w, input logic de);
      bus.sample_valid  = sv;
      bus.sample_temp   = t;
      bus.sample_precip = p;
      bus.sample_wind   = w;
      bus.day_end       = de;
      @(negedge CLOCK_50);
      bus.sample_valid  = 1'b0;
      bus.day_end       = 1'b0;
   endtask

   task automatic idle();
      @(negedge CLOCK_50);
   endtask

   task automatic check_codes(input string tag, input int tmax, input int tmin,
                              input int pr, input int wd);
      check({tag, ".tmax"},   32'(bus.out_temp_max),      32'(tmax));
      check({tag, ".tmin"},   32'(bus.out_temp_min),      32'(tmin));
      check({tag, ".precip"}, 32'(bus.out_precipitation), 32'(pr));
      check({tag, ".wind"},   32'(bus.out_wind),          32'(wd));
   endtask

   initial begin
      rst               = 1'b1;
      bus.sample_valid  = 1'b0;
      bus.sample_temp   = '0;
      bus.sample_precip = '0;
      bus.sample_wind   = '0;
      bus.day_end       = 1'b0;
      bus.feat_ready    = 1'b0;
      idle();
      idle();
      check("rst.valid", 32'(bus.feat_valid), 0);
      check("rst.overrun", 32'(bus.overrun), 0);
      check_codes("rst", 0, 0, 0, 0);
      rst = 1'b0;
      idle();

      // Case 1: three samples then day_end.
      drive(1, 20, 3, 7, 0);
      drive(1, 25, 5, 4, 0);
      check("c1.no_early_valid", 32'(bus.feat_valid), 0);
      drive(1, 18, 0, 2, 1);
      check("c1.valid", 32'(bus.feat_valid), 1);
      check_codes("c1", 9, 7, 2, 3);
`ifdef DFB_SAMPLE_CNT_EN
      check("c1.cnt", 32'(bus.out_sample_cnt), 3);
`endif
      idle();
      check("c1.hold_valid", 32'(bus.feat_valid), 1);
      bus.feat_ready = 1'b1;
      idle();
      check("c1.drained", 32'(bus.feat_valid), 0);
      bus.feat_ready = 1'b0;

      // Case 2: clamp low and high, sample with day_end in the same cycle.
      drive(1, -20, 0, 0, 1);
      check("c2a.valid", 32'(bus.feat_valid), 1);
      check_codes("c2a", 0, 0, 0, 0);
      bus.feat_ready = 1'b1;
      idle();
      bus.feat_ready = 1'b0;
      drive(1, 100, 0, 0, 1);
      check("c2b.valid", 32'(bus.feat_valid), 1);
      check_codes("c2b", 15, 15, 0, 0);
      bus.feat_ready = 1'b1;
      idle();
      bus.feat_ready = 1'b0;

      // Case 3: second day dropped into a stalled slot; samples still accumulate.
      drive(1, 10, 4, 6, 1);
      check_codes("c3a", 5, 5, 1, 3);
      check("c3a.overrun", 32'(bus.overrun), 0);
      drive(1, 40, 40, 40, 1);
      check("c3.overrun", 32'(bus.overrun), 1);
      check("c3.valid_held", 32'(bus.feat_valid), 1);
      check_codes("c3held", 5, 5, 1, 3);
      drive(1, -12, 8, 10, 0);
      bus.feat_ready = 1'b1;
      idle();
      check("c3.second_absent", 32'(bus.feat_valid), 0);
      bus.feat_ready = 1'b0;
      drive(0, 0, 0, 0, 1);
      check("c3c.valid", 32'(bus.feat_valid), 1);
      check_codes("c3c", 0, 0, 2, 5);
      bus.feat_ready = 1'b1;
      idle();
      bus.feat_ready = 1'b0;

      // Case 4: load on the same cycle as a transfer.
      drive(1, 0, 0, 0, 1);
      check("c4a.valid", 32'(bus.feat_valid), 1);
      check_codes("c4a", 3, 3, 0, 0);
      bus.feat_ready = 1'b1;
      drive(1, 60, 20, 30, 1);
      check("c4b.valid", 32'(bus.feat_valid), 1);
      check_codes("c4b", 15, 15, 5, 15);
      idle();
      check("c4.drained", 32'(bus.feat_valid), 0);
      bus.feat_ready = 1'b0;

      // Case 5: empty day, then asynchronous reset mid-day with a held slot.
      drive(0, 0, 0, 0, 1);
      check("c5.empty_day", 32'(bus.feat_valid), 0);
      drive(1, 20, 4, 4, 1);
      check("c5.slot_full", 32'(bus.feat_valid), 1);
      drive(1, 30, 30, 30, 0);
      #2 rst = 1'b1;
      #1;
      check("c5.async_valid", 32'(bus.feat_valid), 0);
      check("c5.async_overrun", 32'(bus.overrun), 0);
      check("c5.async_tmax", 32'(bus.out_temp_max), 0);
      idle();
      rst = 1'b0;
      drive(0, 0, 0, 0, 1);
      check("c5.after_rst_valid", 32'(bus.feat_valid), 0);
      check("c5.after_rst_overrun", 32'(bus.overrun), 0);
      check_codes("c5rst", 0, 0, 0, 0);
`ifdef DFB_SAMPLE_CNT_EN
      check("c5.cnt", 32'(bus.out_sample_cnt), 0);
`endif

      // Case 6: precipitation sum and sample count saturation.
      for (int i = 0; i < 299; i++) drive(1, 0, 255, 0, 0);
      drive(1, 0, 255, 0, 1);
      check("c6.valid", 32'(bus.feat_valid), 1);
      check_codes("c6", 3, 3, 15, 0);
`ifdef DFB_SAMPLE_CNT_EN
      check("c6.cnt", 32'(bus.out_sample_cnt), 255);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/daily_feature_builder.md
DAILY_FEATURE_BUILDER -- requirements
Module: daily_feature_builder

Interface
REQ-001 Parameter TEMP_OFFSET, default 12: signed bias added to temperature before scaling.
REQ-002 Parameter TEMP_SHIFT, default 2: right-shift applied to biased temperature.
REQ-003 Parameter PRECIP_SHIFT, default 2: right-shift applied to the daily precipitation total.
REQ-004 Parameter WIND_SHIFT, default 1: right-shift applied to the daily peak wind.
REQ-005 CLOCK_50  in  1  clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 sample_valid  in  1  one raw weather sample is present this cycle.
REQ-008 sample_temp  in  8  signed temperature, degC.
REQ-009 sample_precip  in  8  unsigned precipitation, mm.
REQ-010 sample_wind  in  8  unsigned wind speed, m/s.
REQ-011 day_end  in  1  single-cycle pulse that closes the current day.
REQ-012 feat_ready  in  1  downstream classifier accepts the feature set.
REQ-013 feat_valid  out  1  feature set is held and stable.
REQ-014 out_temp_max, out_temp_min, out_precipitation, out_wind  out  4 each  quantized daily features.
REQ-015 overrun  out  1  sticky flag: a completed day was dropped.

Function
REQ-016 Accumulator FSM states are EMPTY (no samples this day) and ACCUM (at least one sample accepted).
REQ-017 EMPTY->ACCUM on sample_valid; ACCUM->EMPTY on day_end; all other cases hold state.
REQ-018 On the first sample of a day the accumulators load directly: tmax=tmin=temp, psum=precip, wmax=wind.
REQ-019 On later samples: tmax=max, tmin=min (signed compares), psum saturating 12-bit add, wmax=max.
REQ-020 When sample_valid and day_end occur in the same cycle, the sample belongs to the closing day.
REQ-021 A day_end in EMPTY without a simultaneous sample is ignored: no output, no flag.
REQ-022 Temperature code = clamp((T+TEMP_OFFSET) >>> TEMP_SHIFT, 0, 15), evaluated at 10-bit signed width.
REQ-023 Precipitation code = min(psum >> PRECIP_SHIFT, 15); wind code = min(wmax >> WIND_SHIFT, 15).
REQ-024 A single output slot holds the codes, and feat_valid rises on the cycle after the closing day_end (latency 1).
REQ-025 The slot loads when it is empty, or when feat_valid&&feat_ready in the same cycle (back-to-back allowed).
REQ-026 While feat_valid=1 and feat_ready=0, all outputs remain stable.
REQ-027 feat_valid clears after a feat_valid&&feat_ready transfer unless a new load occurs that cycle.
REQ-028 A day closes into a full, non-draining slot: the new day is discarded, the slot is kept, overrun=1, and the accumulators restart in EMPTY.
REQ-029 Samples arriving while the slot is full still accumulate normally into the next day.

Reset
REQ-030 rst forces EMPTY, all accumulators to 0, feat_valid=0, all four feature outputs to 0, and overrun=0, independent of the clock.
REQ-031 rst asserted mid-day discards the partial day and any held slot; after deassertion, only an explicit day_end produces output.

Configuration
REQ-032 With macro DFB_SAMPLE_CNT_EN defined, output out_sample_cnt[7:0] carries the number of samples in the held day.
REQ-033 out_sample_cnt counts samples with saturation at 255, loads together with the slot, and resets to 0.
REQ-034 Without DFB_SAMPLE_CNT_EN, neither the port nor the counter exists, and all other behaviour is identical.

Structure
REQ-035 Shared package weather_pkg holds FEAT_W=4, the accumulator state enum, and the 12-bit precipitation-sum width constant.
REQ-036 Sub-module feature_quantizer holds the combinational clamp/shift for one field and is instantiated four times.

Verification
REQ-037 Case 1: samples (20,3,7), (25,5,4), (18,0,2) then day_end -> next cycle feat_valid=1, codes tmax=9, tmin=7, precip=2, wind=3.
REQ-038 Case 2: single sample temp=-20 with day_end in the same cycle -> tmax=tmin=0; sample temp=100 -> both codes 15.
REQ-039 Case 3: hold feat_ready=0 across two day_end pulses -> first day's codes held, overrun=1; after ready, the second day is absent.
REQ-040 Case 4: feat_ready=1 and a new day_end on the same cycle as a transfer -> feat_valid stays 1 and codes update with no gap.
REQ-041 Case 5: day_end with no samples -> feat_valid stays 0; rst mid-day followed by day_end -> no output and all outputs 0.
REQ-042 Case 6: 300 samples of precip=255 -> psum saturates at 4095, precip code 15, and with DFB_SAMPLE_CNT_EN out_sample_cnt=255.
